// File: rtl/rv32_pkg.sv
// Shared RV32I types and constants for the writeback stage.
// Optional build macro used by the stage: WB_INSTRET_EN (retired-write counter).
package rv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned INSTRET_W  = 64;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_WAIT_LOAD = 2'd1,
        WB_WRITE     = 2'd2
    } wb_state_t;

    // Context held across the wait for a load response
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            addr;
    } load_ctx_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage retire handshake.
interface writeback_stage_if;
    import rv32_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rd;
    wb_sel_t               in_wb_sel;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_pc_plus4;
    logic [2:0]            in_funct3;

    modport master (
        output in_valid, in_rd, in_wb_sel, in_alu_result, in_pc_plus4, in_funct3,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_wb_sel, in_alu_result, in_pc_plus4, in_funct3,
        output in_ready
    );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Load byte/half/word extraction with sign or zero extension from an aligned word.
module load_align
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data_c,
    output logic            illegal_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_c    = '0;
        illegal_c = 1'b0;
        case (funct3)
            F3_LB:   data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data_c = rdata;
            F3_LBU:  data_c = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data_c = {{(XLEN-16){1'b0}}, half_sel};
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: retires instructions into the register file write port.
// Optional: define WB_INSTRET_EN to add a 64-bit count of WRITE cycles (instret).
module writeback_stage
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    writeback_stage_if.slave      wb,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [REG_ADDR_W-1:0] register_write,
    output logic [XLEN-1:0]       write_data,
    output logic                  register_write_enable,
    output logic                  illegal_load
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0]  instret
`endif
);

    wb_state_t             state, state_d;
    load_ctx_t             ctx, ctx_d;
    logic [REG_ADDR_W-1:0] reg_d;
    logic [XLEN-1:0]       data_d;
    logic                  we_d;
    logic                  ill_d;
    logic                  accept;
    logic [XLEN-1:0]       align_data;
    logic                  align_illegal;

    assign wb.in_ready = (state != WB_WAIT_LOAD);
    assign accept      = wb.in_valid && wb.in_ready;

    load_align u_load_align (
        .rdata     (mem_rdata),
        .addr      (ctx.addr),
        .funct3    (ctx.funct3),
        .data_c    (align_data),
        .illegal_c (align_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= WB_IDLE;
            ctx                   <= '0;
            register_write        <= '0;
            write_data            <= '0;
            register_write_enable <= 1'b0;
            illegal_load          <= 1'b0;
        end else begin
            state                 <= state_d;
            ctx                   <= ctx_d;
            register_write        <= reg_d;
            write_data            <= data_d;
            register_write_enable <= we_d;
            illegal_load          <= ill_d;
        end
    end

    // Next state and next output register values; outputs hold unless a write is staged
    always_comb begin
        state_d = state;
        ctx_d   = ctx;
        reg_d   = register_write;
        data_d  = write_data;
        we_d    = 1'b0;
        ill_d   = 1'b0;
        case (state)
            WB_IDLE, WB_WRITE: begin
                state_d = WB_IDLE;
                if (accept) begin
                    if (wb.in_wb_sel == WB_LOAD) begin
                        state_d = WB_WAIT_LOAD;
                        ctx_d   = '{rd: wb.in_rd, funct3: wb.in_funct3,
                                    addr: wb.in_alu_result[1:0]};
                    end else begin
                        state_d = WB_WRITE;
                        reg_d   = wb.in_rd;
                        data_d  = (wb.in_wb_sel == WB_PC4) ? wb.in_pc_plus4 : wb.in_alu_result;
                        we_d    = (wb.in_wb_sel != WB_NONE) && (wb.in_rd != '0);
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d = WB_WRITE;
                    reg_d   = ctx.rd;
                    data_d  = align_illegal ? '0 : align_data;
                    we_d    = !align_illegal && (ctx.rd != '0);
                    ill_d   = align_illegal;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

`ifdef WB_INSTRET_EN
    // One count per WRITE cycle, wrapping naturally at 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (state == WB_WRITE) begin
            instret <= instret + INSTRET_W'(1);
        end
    end
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core. Sits directly upstream of the register file and drives its write port: register_write, write_data and register_write_enable.
- Accepts retiring instructions from the memory stage with a valid/ready handshake.
- Waits for the data-memory load response when needed, and performs load byte/half extraction with sign or zero extension.
- Issues exactly one register-file write pulse per retired instruction.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  single core clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  memory stage presents a retiring instruction
- in_ready  output  1  stage can accept an instruction this cycle
- in_rd  input  5  destination register index
- in_wb_sel  input  2  writeback source: 0=NONE, 1=ALU, 2=LOAD, 3=PC4
- in_alu_result  input  32  ALU result; for loads, the byte address
- in_pc_plus4  input  32  link value for JAL/JALR
- in_funct3  input  3  load size/sign: 0=LB 1=LH 2=LW 4=LBU 5=LHU
- mem_rvalid  input  1  data memory load response valid
- mem_rdata  input  32  aligned 32-bit word containing the load data
- register_write  output  5  register file write index
- write_data  output  32  register file write data
- register_write_enable  output  1  one-cycle write strobe
- illegal_load  output  1  one-cycle pulse: load with reserved funct3 (3, 6, 7)

Behaviour:
- Reset (asynchronous, on rst_n low):
  - State goes to IDLE.
  - register_write=0, write_data=0, register_write_enable=0, illegal_load=0.
  - in_ready=1 once rst_n is released.
- Handshake: an instruction transfers on a rising edge where in_valid && in_ready. in_ready = (state != WAIT_LOAD).
- FSM:
  - IDLE / WRITE, accept with wb_sel=ALU, PC4 or NONE → WRITE. Next cycle presents the result (latency 1).
  - IDLE / WRITE, accept with wb_sel=LOAD → WAIT_LOAD. Latch rd, funct3 and addr[1:0].
  - WAIT_LOAD, mem_rvalid=1 → WRITE with the extracted data. Write appears the cycle after rvalid.
  - WAIT_LOAD, mem_rvalid=0 → stay; in_ready=0 (back-pressure).
  - WRITE, no accept → IDLE.
  - Back-to-back accepts are allowed: throughput is 1 instruction/cycle for non-loads.
- Output registers:
  - register_write_enable is high for exactly one cycle in WRITE.
  - It is forced 0 when rd==0 or wb_sel==NONE. write_data still updates in those cases.
  - Outputs hold their last value while IDLE/WAIT_LOAD; enable is 0 there.
- Load extraction:
  - Byte lane = addr[1:0] for LB/LBU; half = addr[1] for LH/LHU (addr[0] ignored); LW ignores addr[1:0].
  - Sign extension for LB/LH; zero extension for LBU/LHU.
- Illegal funct3 on a load:
  - Still waits for mem_rvalid.
  - Then pulses illegal_load, writes write_data=0, and suppresses enable.
- mem_rvalid outside WAIT_LOAD is ignored.
- Reset mid-load: the pending load is discarded; a later rvalid with no load outstanding is ignored.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - Adds output instret, 64 bits.
  - Reset 0; increments by 1 on every WRITE cycle, including rd==0, NONE and illegal loads.
  - Wraps modulo 2^64. The value is visible the cycle after the write.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rv32_pkg:
  - wb_sel_t enum (WB_NONE, WB_ALU, WB_LOAD, WB_PC4).
  - funct3 constants F3_LB/LH/LW/LBU/LHU.
  - XLEN.
- One sub-module: load_align. Combinational: (mem_rdata, addr[1:0], funct3) → extracted data plus illegal flag.
- The FSM stays in writeback_stage.

Test Plan:
- ALU write: rd=5, wb_sel=ALU, alu=0xDEADBEEF → next cycle enable=1, register_write=5, write_data=0xDEADBEEF; enable=0 the following cycle.
- x0 suppression: rd=0, ALU=0x1234 → enable stays 0. Then PC4 with rd=1, pc_plus4=0x104 → enable=1, data 0x104.
- LB with sign extension: addr=0x1003, funct3=0, rdata=0x80FF_0000, rvalid 3 cycles later.
  - in_ready=0 for 3 cycles.
  - write_data=0xFFFFFF80 the cycle after rvalid.
- LHU / LH: addr=0x2002, rdata=0x8001_7FFF.
  - LHU → 0x00008001.
  - LH → 0xFFFF8001.
- Illegal and reset:
  - funct3=3 load with rvalid → illegal_load pulses, enable 0.
  - New load, then rst_n low mid-wait, then rvalid=1 after release → no write, in_ready=1.
- WB_INSTRET_EN: 10 back-to-back ALU ops, one with rd=0 → instret=10.
